// File: rtl/alu_mul_sequencer.sv
// Shift-and-add unsigned multiplier controller that borrows the shared ALU adder.
// One DATA_WIDTH x DATA_WIDTH request at a time; the full product is returned on a valid/ready port.

package isa_shared;
  localparam logic [2:0] ALU_ADD = 3'b000;
endpackage

module alu_mul_sequencer
  import isa_shared::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [DATA_WIDTH-1:0] i_req_a,
  input  logic [DATA_WIDTH-1:0] i_req_b,
  output logic                  o_resp_valid,
  input  logic                  i_resp_ready,
  output logic [DATA_WIDTH-1:0] o_resp_hi,
  output logic [DATA_WIDTH-1:0] o_resp_lo,
  output logic                  o_busy,
  output logic [DATA_WIDTH-1:0] o_alu_a,
  output logic [DATA_WIDTH-1:0] o_alu_b,
  output logic [2:0]            o_alu_op,
  input  logic [DATA_WIDTH-1:0] i_alu_result
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // Valid must be held until ready; ready never depends combinationally on valid.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_hi;
  logic [DATA_WIDTH-1:0] r_lo;
  logic [DATA_WIDTH-1:0] r_mcand;
  logic [CW-1:0]         r_cnt;
  logic                  r_req_ready;
  logic                  r_resp_valid;
  logic                  r_busy;

  // The ALU has no usable carry out; a wrapped sum is smaller than the addend.
  logic w_carry;
  logic w_run;
  assign w_run   = (r_state == S_RUN);
  assign w_carry = (i_alu_result < r_hi);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_hi         <= '0;
      r_lo         <= '0;
      r_mcand      <= '0;
      r_cnt        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid && r_req_ready) begin
            r_hi        <= '0;
            r_lo        <= i_req_b;
            r_mcand     <= i_req_a;
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_RUN;
          end
        end
        S_RUN: begin
          r_hi  <= {w_carry, i_alu_result[DATA_WIDTH-1:1]};
          r_lo  <= {i_alu_result[0], r_lo[DATA_WIDTH-1:1]};
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(DATA_WIDTH - 1)) begin
            r_resp_valid <= 1'b1;
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (i_resp_ready) begin
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_resp_valid = r_resp_valid;
  assign o_busy       = r_busy;
  assign o_resp_hi    = r_resp_valid ? r_hi : '0;
  assign o_resp_lo    = r_resp_valid ? r_lo : '0;

  assign o_alu_a  = w_run ? r_hi : '0;
  assign o_alu_b  = (w_run && r_lo[0]) ? r_mcand : '0;
  assign o_alu_op = ALU_ADD;

endmodule
